// File: rtl/io_bus_master_pkg.sv
// Shared IO bus encoding: widths, ctrl bit positions, access size codes and FSM states.
// Responders import this package so that they decode the same ctrl encoding the master drives.
package io_bus_master_pkg;

  localparam int IO_BUS_WIDTH_ADDR = 32;
  localparam int IO_BUS_WIDTH_DATA = 32;
  localparam int IO_BUS_WIDTH_CTRL = 4;

  localparam int CTRL_RD_BIT   = 0;
  localparam int CTRL_WR_BIT   = 1;
  localparam int CTRL_SIZE_LSB = 2;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_e;

  // Misaligned halves/words and the reserved size code never reach the bus.
  function automatic logic req_is_bad(size_e size, logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_HALF:    bad = addr_lo[0];
      SIZE_WORD:    bad = (addr_lo != 2'b00);
      SIZE_ILLEGAL: bad = 1'b1;
      default:      bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic [IO_BUS_WIDTH_DATA-1:0] mask_wdata(size_e size,
                                                              logic [IO_BUS_WIDTH_DATA-1:0] wdata);
    logic [IO_BUS_WIDTH_DATA-1:0] masked;
    case (size)
      SIZE_BYTE: masked = {24'b0, wdata[7:0]};
      SIZE_HALF: masked = {16'b0, wdata[15:0]};
      default:   masked = wdata;
    endcase
    return masked;
  endfunction

endpackage

// File: rtl/io_bus_master_if.sv
// Request/response handshake between the memory stage (master) and the IO bus initiator (slave).
interface io_bus_master_if;
  import io_bus_master_pkg::*;

  logic                         req_valid;
  logic                         req_ready;
  logic                         req_we;
  logic [1:0]                   req_size;
  logic                         req_unsigned;
  logic [IO_BUS_WIDTH_ADDR-1:0] req_addr;
  logic [IO_BUS_WIDTH_DATA-1:0] req_wdata;
  logic                         rsp_valid;
  logic [IO_BUS_WIDTH_DATA-1:0] rsp_rdata;
  logic                         rsp_err;
  logic                         stall;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, stall
  );

endinterface

// File: rtl/io_bus_master_load_extend.sv
// Sign/zero extension of raw load data: byte from bit 7, half from bit 15, word unchanged.
module load_extend
  import io_bus_master_pkg::*;
(
  input  size_e                        size,
  input  logic                         is_unsigned,
  input  logic [IO_BUS_WIDTH_DATA-1:0] raw,
  output logic [IO_BUS_WIDTH_DATA-1:0] ext
);

  always_comb begin
    ext = raw;
    case (size)
      SIZE_BYTE: ext = {{24{~is_unsigned & raw[7]}}, raw[7:0]};
      SIZE_HALF: ext = {{16{~is_unsigned & raw[15]}}, raw[15:0]};
      default:   ext = raw;
    endcase
  end

endmodule

// File: rtl/io_bus_master.sv
// CPU-side IO bus initiator: one load/store at a time, stalls the pipeline until completion.
// rst_n keeps the codebase port name but is a synchronous, active-high reset.
module io_bus_master
  import io_bus_master_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  io_bus_master_if.slave               cpu,
  output logic                         BC,
  output logic [IO_BUS_WIDTH_ADDR-1:0] addr,
  output logic [IO_BUS_WIDTH_CTRL-1:0] ctrl,
  inout  wire  [IO_BUS_WIDTH_DATA-1:0] data
);

  localparam logic [2:0] LAT_INIT = 3'(READ_LATENCY);

  state_e                       state_q, state_d;
  logic                         we_q, we_d;
  size_e                        size_q, size_d;
  logic                         uns_q, uns_d;
  logic [IO_BUS_WIDTH_ADDR-1:0] addr_q, addr_d;
  logic [IO_BUS_WIDTH_DATA-1:0] wdata_q, wdata_d;
  logic [2:0]                   cnt_q, cnt_d;

  logic                         rsp_valid_q, rsp_valid_d;
  logic [IO_BUS_WIDTH_DATA-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                         rsp_err_q, rsp_err_d;
  logic                         stall_q, stall_d;
  logic                         req_ready_q, req_ready_d;
  logic                         bc_q, bc_d;
  logic [IO_BUS_WIDTH_ADDR-1:0] bus_addr_q, bus_addr_d;
  logic [IO_BUS_WIDTH_CTRL-1:0] ctrl_q, ctrl_d;
  logic                         drive_q, drive_d;
  logic [IO_BUS_WIDTH_DATA-1:0] dout_q, dout_d;

  logic [IO_BUS_WIDTH_DATA-1:0] ext_data;
  logic                         req_bad;

  load_extend u_load_extend (
    .size        (size_q),
    .is_unsigned (uns_q),
    .raw         (data),
    .ext         (ext_data)
  );

  assign req_bad = req_is_bad(size_e'(cpu.req_size), cpu.req_addr[1:0]);

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cpu.req_valid) begin
          we_d    = cpu.req_we;
          size_d  = size_e'(cpu.req_size);
          uns_d   = cpu.req_unsigned;
          addr_d  = cpu.req_addr;
          wdata_d = cpu.req_wdata;
          cnt_d   = cpu.req_we ? 3'd0 : LAT_INIT;
          if (req_bad) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 3'd0) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? '0 : ext_data;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Bus-facing outputs are registered from the next state so nothing glitches between cycles.
    bc_d        = (state_d == ST_ACCESS);
    stall_d     = bc_d;
    req_ready_d = (state_d == ST_IDLE);
    bus_addr_d  = bc_d ? addr_d : '0;
    ctrl_d      = bc_d ? {size_d, we_d, ~we_d} : '0;
    drive_d     = bc_d & we_d;
    dout_d      = drive_d ? mask_wdata(size_d, wdata_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      size_q      <= SIZE_BYTE;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      stall_q     <= 1'b0;
      req_ready_q <= 1'b1;
      bc_q        <= 1'b0;
      bus_addr_q  <= '0;
      ctrl_q      <= '0;
      drive_q     <= 1'b0;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      stall_q     <= stall_d;
      req_ready_q <= req_ready_d;
      bc_q        <= bc_d;
      bus_addr_q  <= bus_addr_d;
      ctrl_q      <= ctrl_d;
      drive_q     <= drive_d;
      dout_q      <= dout_d;
    end
  end

  assign cpu.req_ready = req_ready_q;
  assign cpu.rsp_valid = rsp_valid_q;
  assign cpu.rsp_rdata = rsp_rdata_q;
  assign cpu.rsp_err   = rsp_err_q;
  assign cpu.stall     = stall_q;
  assign BC            = bc_q;
  assign addr          = bus_addr_q;
  assign ctrl          = ctrl_q;
  assign data          = drive_q ? dout_q : 'z;

endmodule

// File: doc/io_bus_master.md
# io_bus_master

CPU-side initiator for the shared IO bus. Accepts one load/store request at a time from the memory stage and drives `addr`/`ctrl`/`data` onto the bus, where the bus address decoder routes them to RAM, the LED/switch interface or the numeric-LED interface. Byte and halfword reads are returned sign- or zero-extended. The block stalls the pipeline until each transaction completes.

## Interface
- `READ_LATENCY`, default 1: cycles between a read being presented on the bus and responder data becoming valid. Legal range is 0–7.
- `clk` input, 1 bit: system clock.
- `rst_n` input, 1 bit: reset. The name follows the codebase port name, but this reset is synchronous and active-high.
- `req_valid` input, 1 bit: a request is present.
- `req_ready` output, 1 bit: the block accepts a request this cycle.
- `req_we` input, 1 bit: 1 = store, 0 = load.
- `req_size` input, 2 bits: 00 = byte, 01 = half, 10 = word. Code 11 is illegal.
- `req_unsigned` input, 1 bit: zero-extend the load result instead of sign-extending it.
- `req_addr` input, 32 bits: byte address.
- `req_wdata` input, 32 bits: store data, right-aligned.
- `rsp_valid` output, 1 bit: one-cycle completion pulse.
- `rsp_rdata` output, 32 bits: extended load data. It is 0 for stores.
- `rsp_err` output, 1 bit: the request was misaligned or illegal, and no bus cycle was issued. Valid only when `rsp_valid` is high.
- `stall` output, 1 bit: high from acceptance until the cycle of `rsp_valid`, exclusive.
- `BC` output, 1 bit: bus query. High while a bus cycle is active.
- `addr` output, 32 bits: bus address.
- `ctrl` output, 4 bits: bus control. Bit 0 = read, bit 1 = write, bits [3:2] = size code.
- `data` inout, 32 bits: bus data. The block drives it only during write cycles; otherwise it is high-Z.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid` the block latches `we`, `size`, `unsigned`, `addr` and `wdata`.
  - Misaligned or illegal requests go to RESP with the error flag set. These are: half with addr[0] = 1, word with addr[1:0] ≠ 0, or size 11.
  - All other requests go to ACCESS. The wait counter loads READ_LATENCY for reads and 0 for writes.
- **ACCESS**
  - `BC` = 1, `addr` = latched address.
  - `ctrl` = {size, we, ~we}.
  - For writes, `data` = latched wdata masked to size (upper bits 0).
  - The counter decrements each cycle. When it reaches 0, a read samples `data` into a holding register and the FSM goes to RESP.
- **RESP**
  - `rsp_valid` = 1 for exactly one cycle.
  - `rsp_rdata` = held data extended per size and unsigned: byte from bit 7, half from bit 15, word unchanged.
  - `rsp_err` = error flag.
  - Next state is IDLE.
- `req_ready` = 0 outside IDLE. Requests presented then are ignored, not queued.
- Outside ACCESS: `addr` = 0, `ctrl` = 0, `BC` = 0, `data` = Z. There are no spurious strobes between transactions.
- Read data lives in the low bits of the bus; the responder does lane selection. The master never drives `data` on a read cycle.
- Back-to-back requests: a new request may be accepted in the cycle after RESP, i.e. when IDLE is re-entered.
- Reset mid-transaction: the FSM returns to IDLE with no `rsp_valid` and releases the bus the next cycle. The aborted request is lost.

## Timing
- Reset values: state IDLE; `req_ready` = 1; `rsp_valid` = 0; `rsp_rdata` = 0; `rsp_err` = 0; `stall` = 0; `BC` = 0; `addr` = 0; `ctrl` = 0; `data` = Z.
- Accept at cycle T means `req_valid` and `req_ready` are both high in cycle T.
- Write:
  - ACCESS in T+1. The write strobe is exactly one cycle.
  - `rsp_valid` in T+2.
- Read:
  - ACCESS in T+1 through T+1+READ_LATENCY, with the read strobe held.
  - `data` is sampled at the rising edge ending T+1+READ_LATENCY.
  - `rsp_valid` in T+2+READ_LATENCY.
- Error: `rsp_valid` with `rsp_err` = 1 in T+1. `BC` and `ctrl` stay 0 throughout.
- `stall` is high from T+1 up to, but not including, the `rsp_valid` cycle. All outputs are registered.

## Structure
- Bus widths belong in the shared `param.v`: `IO_BUS_WIDTH_ADDR` = 32, `IO_BUS_WIDTH_DATA` = 32, `IO_BUS_WIDTH_CTRL` = 4. The ctrl bit positions and size codes are defined there too, so that the responders decode the same encoding.
- One combinational sub-module, `load_extend`: inputs are size, unsigned and raw 32-bit data; output is the 32-bit extended value.
- The `data` tri-state lives in the top of this block only.

## Test plan
- Word write, addr 0x0000_0100, wdata 0xDEAD_BEEF:
  - T+1: `ctrl` = 4'b1010, `BC` = 1, `data` = 0xDEADBEEF.
  - T+2: `rsp_valid` with `rsp_err` = 0.
  - T+3: `data` = Z.
- Byte read, signed, with the bus model returning 0x0000_0080 and READ_LATENCY = 1:
  - Read strobe asserted in T+1 and T+2.
  - `rsp_rdata` = 0xFFFF_FF80 in T+3.
  - Repeating with `req_unsigned` = 1 gives 0x0000_0080.
- Half read at 0xFFFF_F062 returning 0x0000_8001: `rsp_rdata` = 0xFFFF_8001.
- Misaligned word at 0x0000_0102: `rsp_valid` with `rsp_err` = 1 in T+1, and `ctrl`/`BC` stay 0 throughout.
- Back-to-back write then read with `req_valid` held high:
  - The second request is accepted only in the cycle after the first `rsp_valid`.
  - `req_ready` is low during ACCESS.
- Reset asserted during read ACCESS:
  - No `rsp_valid` is produced.
  - The next cycle shows `ctrl` = 0, `BC` = 0 and `req_ready` = 1.
